// File: rtl/itlb_refill_ctrl_if.sv
// Handshake bundle between the ITLB refill controller, the lookup, the PTW and the entry array.
// The master modport is the controller; the slave modport is its environment.
interface itlb_refill_ctrl_if #(
  parameter int unsigned ENTRY_NUM = 32,
  parameter int unsigned MXLEN     = 64,
  parameter int unsigned VPN_W     = 27
);
  logic                 flush;
  logic                 miss_valid;
  logic [VPN_W-1:0]     miss_vpn;
  logic                 miss_ready;
  logic                 ptw_req_valid;
  logic                 ptw_req_ready;
  logic [VPN_W-1:0]     ptw_req_vpn;
  logic                 ptw_resp_valid;
  logic [MXLEN-1:0]     ptw_resp_pte;
  logic                 ptw_resp_fault;
  logic [ENTRY_NUM-1:0] wr_en;
  logic [MXLEN-1:0]     pte_wr;
  logic [ENTRY_NUM-1:0] entry_valid;
  logic                 refill_done;
  logic                 refill_fault;

  modport master (
    input  flush, miss_valid, miss_vpn, ptw_req_ready, ptw_resp_valid, ptw_resp_pte,
           ptw_resp_fault,
    output miss_ready, ptw_req_valid, ptw_req_vpn, wr_en, pte_wr, entry_valid, refill_done,
           refill_fault
  );

  modport slave (
    output flush, miss_valid, miss_vpn, ptw_req_ready, ptw_resp_valid, ptw_resp_pte,
           ptw_resp_fault,
    input  miss_ready, ptw_req_valid, ptw_req_vpn, wr_en, pte_wr, entry_valid, refill_done,
           refill_fault
  );
endinterface

// File: rtl/itlb_refill_ctrl.sv
// ITLB write-side controller: turns a lookup miss into a PTW request, picks a victim entry,
// writes the returned leaf PTE and owns the per-entry valid bits (including sfence/flush).
module itlb_refill_ctrl #(
  parameter int unsigned ENTRY_NUM = 32,
  parameter int unsigned MXLEN     = 64,
  parameter int unsigned VPN_W     = 27
) (
  input logic              clk,
  input logic              rstn,
  itlb_refill_ctrl_if.master bus
);

  localparam int unsigned PtrW = (ENTRY_NUM > 1) ? $clog2(ENTRY_NUM) : 1;

  typedef enum logic [2:0] {StIdle, StReq, StWait, StWrite, StDrain} state_e;

  state_e               state_q;
  logic [VPN_W-1:0]     vpn_q;
  logic [MXLEN-1:0]     pte_q;
  logic                 fault_q;
  logic [ENTRY_NUM-1:0] valid_q;
  logic [PtrW-1:0]      rr_q;

  logic [PtrW-1:0]      free_idx;
  logic                 any_free;
  logic [PtrW-1:0]      victim_idx;
  logic [ENTRY_NUM-1:0] victim_oh;
  logic                 in_write;
  logic                 write_ok;

  // Lowest-index invalid entry; scanning downwards lets the lowest one win.
  always_comb begin
    free_idx = '0;
    any_free = 1'b0;
    for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        free_idx = PtrW'(i);
        any_free = 1'b1;
      end
    end
  end

  assign victim_idx = any_free ? free_idx : rr_q;
  assign victim_oh  = {{(ENTRY_NUM-1){1'b0}}, 1'b1} << victim_idx;

  // Flush in the WRITE cycle kills the write and both completion pulses.
  assign in_write = (state_q == StWrite) && !bus.flush;
  assign write_ok = in_write && !fault_q && pte_q[0];

  assign bus.miss_ready    = (state_q == StIdle);
  assign bus.ptw_req_valid = (state_q == StReq);
  assign bus.ptw_req_vpn   = vpn_q;
  assign bus.wr_en         = write_ok ? victim_oh : '0;
  assign bus.pte_wr        = write_ok ? pte_q : '0;
  assign bus.entry_valid   = valid_q;
  assign bus.refill_done   = write_ok;
  assign bus.refill_fault  = in_write && (fault_q || !pte_q[0]);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= StIdle;
      vpn_q   <= '0;
      pte_q   <= '0;
      fault_q <= 1'b0;
      valid_q <= '0;
      rr_q    <= '0;
    end else if (bus.flush) begin
      valid_q <= '0;
      rr_q    <= '0;
      // A PTW response still in flight must be swallowed before new misses are taken.
      if ((state_q == StWait || state_q == StDrain) && !bus.ptw_resp_valid) begin
        state_q <= StDrain;
      end else begin
        state_q <= StIdle;
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.miss_valid) begin
            vpn_q   <= bus.miss_vpn;
            state_q <= StReq;
          end
        end
        StReq: begin
          if (bus.ptw_req_ready) state_q <= StWait;
        end
        StWait: begin
          if (bus.ptw_resp_valid) begin
            pte_q   <= bus.ptw_resp_pte;
            fault_q <= bus.ptw_resp_fault;
            state_q <= StWrite;
          end
        end
        StWrite: begin
          if (write_ok) begin
            valid_q <= valid_q | victim_oh;
            if (!any_free) begin
              rr_q <= (rr_q == PtrW'(ENTRY_NUM - 1)) ? '0 : rr_q + PtrW'(1);
            end
          end
          state_q <= StIdle;
        end
        StDrain: begin
          if (bus.ptw_resp_valid) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_itlb_refill_ctrl.sv
// Self-checking bench for itlb_refill_ctrl: a small victim/valid model feeds a scoreboard queue
// that is drained as each refill completes.
module tb_itlb_refill_ctrl;

  logic clk;
  logic rstn;
  int   n_cmp;
  int   n_err;

  itlb_refill_ctrl_if #(.ENTRY_NUM(32), .MXLEN(64), .VPN_W(27)) bus ();

  itlb_refill_ctrl #(.ENTRY_NUM(32), .MXLEN(64), .VPN_W(27)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] wr;
    logic [63:0] pte;
    logic        done;
    logic        fault;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_valid;
  int          m_rr;

  // observations of the last refill
  logic [31:0] o_wr;
  logic [63:0] o_pte;
  logic        o_done;
  logic        o_flt;
  int          o_lat;
  logic [26:0] o_vpn;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_push(input logic [63:0] pte, input logic flt);
    exp_t e;
    int   v;
    v = -1;
    for (int i = 31; i >= 0; i--) if (!m_valid[i]) v = i;
    if (v < 0) v = m_rr;
    e.done  = !flt && pte[0];
    e.fault = !e.done;
    e.wr    = e.done ? (32'h1 << v) : 32'h0;
    e.pte   = e.done ? pte : 64'h0;
    if (e.done) begin
      if (m_valid[v]) m_rr = (m_rr + 1) % 32;
      m_valid[v] = 1'b1;
    end
    sb.push_back(e);
  endtask

  // Miss -> immediate PTW ready -> immediate response; captures the WRITE-cycle outputs.
  task automatic drive_refill(input logic [26:0] vpn, input logic [63:0] pte, input logic flt);
    int lat;
    lat = 0;
    bus.miss_vpn   = vpn;
    bus.miss_valid = 1'b1;
    step();
    bus.miss_valid = 1'b0;
    for (int k = 0; k < 8 && !bus.ptw_req_valid; k++) begin step(); lat++; end
    o_vpn = bus.ptw_req_vpn;
    bus.ptw_req_ready = 1'b1;
    step(); lat++;
    bus.ptw_req_ready  = 1'b0;
    bus.ptw_resp_pte   = pte;
    bus.ptw_resp_fault = flt;
    bus.ptw_resp_valid = 1'b1;
    step(); lat++;
    bus.ptw_resp_valid = 1'b0;
    for (int k = 0; k < 8 && !(bus.refill_done || bus.refill_fault); k++) begin step(); lat++; end
    o_wr   = bus.wr_en;
    o_pte  = bus.pte_wr;
    o_done = bus.refill_done;
    o_flt  = bus.refill_fault;
    o_lat  = lat;
    step();
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    step();
    step();
    n_cmp++; if (bus.miss_ready !== 1'b1) begin n_err++;
      $display("FAIL reset_miss_ready: got %b want 1", bus.miss_ready); end
    n_cmp++; if ({bus.ptw_req_valid, bus.refill_done, bus.refill_fault} !== 3'b000) begin n_err++;
      $display("FAIL reset_pulses: got %b want 000",
               {bus.ptw_req_valid, bus.refill_done, bus.refill_fault}); end
    n_cmp++; if (bus.wr_en !== 32'h0 || bus.pte_wr !== 64'h0) begin n_err++;
      $display("FAIL reset_write: got wr=%h pte=%h want 0/0", bus.wr_en, bus.pte_wr); end
    n_cmp++; if (bus.entry_valid !== 32'h0) begin n_err++;
      $display("FAIL reset_valid: got %h want 0", bus.entry_valid); end
    rstn = 1'b1;
    m_valid = '0;
    m_rr = 0;
  endtask

  task automatic test_basic();
    exp_t e;
    model_push(64'h0000_0000_0480_00CF, 1'b0);
    drive_refill(27'h12345, 64'h0000_0000_0480_00CF, 1'b0);
    e = sb.pop_front();
    n_cmp++; if (o_vpn !== 27'h12345) begin n_err++;
      $display("FAIL basic_req_vpn: got %h want 12345", o_vpn); end
    n_cmp++; if (o_lat !== 2) begin n_err++;
      $display("FAIL basic_latency: got %0d want 2", o_lat); end
    n_cmp++; if (o_wr !== e.wr || o_pte !== e.pte) begin n_err++;
      $display("FAIL basic_write: got wr=%h pte=%h want wr=%h pte=%h", o_wr, o_pte, e.wr, e.pte); end
    n_cmp++; if ({o_done, o_flt} !== {e.done, e.fault}) begin n_err++;
      $display("FAIL basic_pulse: got %b%b want %b%b", o_done, o_flt, e.done, e.fault); end
    n_cmp++; if (bus.entry_valid !== 32'h1 || bus.refill_done !== 1'b0) begin n_err++;
      $display("FAIL basic_after: got valid=%h done=%b want 1/0",
               bus.entry_valid, bus.refill_done); end
  endtask

  // Fill the rest, then two replacements that must take entries 0 and 1.
  task automatic test_fill_and_wrap();
    exp_t        e;
    logic [63:0] pte;
    for (int i = 1; i < 34; i++) begin
      pte = {32'h0, 8'(i), 24'h0000C1};
      model_push(pte, 1'b0);
      drive_refill(27'(i), pte, 1'b0);
      e = sb.pop_front();
      n_cmp++; if (o_wr !== e.wr || o_pte !== e.pte || o_done !== 1'b1) begin n_err++;
        $display("FAIL fill_write[%0d]: got wr=%h pte=%h done=%b want wr=%h pte=%h done=1",
                 i, o_wr, o_pte, o_done, e.wr, e.pte); end
      n_cmp++; if (bus.entry_valid !== m_valid) begin n_err++;
        $display("FAIL fill_valid[%0d]: got %h want %h", i, bus.entry_valid, m_valid); end
    end
    n_cmp++; if (o_wr !== 32'h2) begin n_err++;
      $display("FAIL wrap_second_victim: got %h want 00000002", o_wr); end
  endtask

  task automatic test_fault();
    exp_t e;
    for (int k = 0; k < 2; k++) begin
      model_push((k == 0) ? 64'hCF : 64'hCE, (k == 0));
      drive_refill(27'h777, (k == 0) ? 64'hCF : 64'hCE, (k == 0));
      e = sb.pop_front();
      n_cmp++; if ({o_done, o_flt} !== {e.done, e.fault} || o_wr !== e.wr || o_pte !== e.pte)
      begin n_err++;
        $display("FAIL fault_pulse[%0d]: got done=%b flt=%b wr=%h pte=%h want %b %b %h %h",
                 k, o_done, o_flt, o_wr, o_pte, e.done, e.fault, e.wr, e.pte); end
      n_cmp++; if (bus.refill_fault !== 1'b0 || bus.entry_valid !== m_valid) begin n_err++;
        $display("FAIL fault_after[%0d]: got flt=%b valid=%h want 0 %h",
                 k, bus.refill_fault, bus.entry_valid, m_valid); end
    end
    // rr pointer must not have moved: next replacement still hits entry 2
    model_push(64'hC1, 1'b0);
    drive_refill(27'h1, 64'hC1, 1'b0);
    e = sb.pop_front();
    n_cmp++; if (o_wr !== e.wr || o_wr !== 32'h4) begin n_err++;
      $display("FAIL fault_rr_hold: got %h want %h", o_wr, e.wr); end
  endtask

  task automatic test_flush_wait();
    bus.miss_valid = 1'b1;
    step();
    bus.miss_valid    = 1'b0;
    bus.ptw_req_ready = 1'b1;
    step();
    bus.ptw_req_ready = 1'b0;
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    m_valid = '0;
    m_rr = 0;
    n_cmp++; if (bus.entry_valid !== 32'h0) begin n_err++;
      $display("FAIL flush_wait_valid: got %h want 0", bus.entry_valid); end
    for (int k = 0; k < 5; k++) begin
      n_cmp++; if (bus.miss_ready !== 1'b0 || bus.wr_en !== 32'h0) begin n_err++;
        $display("FAIL drain_hold[%0d]: got ready=%b wr=%h want 0/0", k, bus.miss_ready, bus.wr_en); end
      step();
    end
    bus.ptw_resp_pte   = 64'hCF;
    bus.ptw_resp_valid = 1'b1;
    step();
    bus.ptw_resp_valid = 1'b0;
    n_cmp++; if (bus.miss_ready !== 1'b1 || bus.wr_en !== 32'h0) begin n_err++;
      $display("FAIL drain_exit: got ready=%b wr=%h want 1/0", bus.miss_ready, bus.wr_en); end
    // flush with resp in the same WAIT cycle goes straight back to IDLE
    bus.miss_valid = 1'b1;
    step();
    bus.miss_valid    = 1'b0;
    bus.ptw_req_ready = 1'b1;
    step();
    bus.ptw_req_ready  = 1'b0;
    bus.flush          = 1'b1;
    bus.ptw_resp_valid = 1'b1;
    step();
    bus.flush          = 1'b0;
    bus.ptw_resp_valid = 1'b0;
    n_cmp++; if (bus.miss_ready !== 1'b1) begin n_err++;
      $display("FAIL flush_resp_same: got ready=%b want 1", bus.miss_ready); end
    // flush with a miss in IDLE: miss dropped
    bus.flush      = 1'b1;
    bus.miss_valid = 1'b1;
    step();
    bus.flush      = 1'b0;
    bus.miss_valid = 1'b0;
    n_cmp++; if (bus.miss_ready !== 1'b1 || bus.ptw_req_valid !== 1'b0) begin n_err++;
      $display("FAIL flush_miss_idle: got ready=%b req=%b want 1/0",
               bus.miss_ready, bus.ptw_req_valid); end
  endtask

  task automatic test_flush_write();
    exp_t e;
    model_push(64'hC1, 1'b0);
    drive_refill(27'h5, 64'hC1, 1'b0);
    e = sb.pop_front();
    n_cmp++; if (o_wr !== e.wr) begin n_err++;
      $display("FAIL flush_write_pre: got %h want %h", o_wr, e.wr); end
    bus.miss_valid = 1'b1;
    step();
    bus.miss_valid    = 1'b0;
    bus.ptw_req_ready = 1'b1;
    step();
    bus.ptw_req_ready  = 1'b0;
    bus.ptw_resp_pte   = 64'hCF;
    bus.ptw_resp_valid = 1'b1;
    step();
    bus.ptw_resp_valid = 1'b0;
    bus.flush          = 1'b1;
    #1;
    n_cmp++; if (bus.wr_en !== 32'h0 || bus.pte_wr !== 64'h0 ||
                 bus.refill_done !== 1'b0 || bus.refill_fault !== 1'b0) begin n_err++;
      $display("FAIL flush_write_kill: got wr=%h pte=%h done=%b flt=%b want all 0",
               bus.wr_en, bus.pte_wr, bus.refill_done, bus.refill_fault); end
    step();
    bus.flush = 1'b0;
    m_valid = '0;
    m_rr = 0;
    n_cmp++; if (bus.entry_valid !== 32'h0 || bus.miss_ready !== 1'b1) begin n_err++;
      $display("FAIL flush_write_after: got valid=%h ready=%b want 0/1",
               bus.entry_valid, bus.miss_ready); end
  endtask

  task automatic test_gap_and_reset();
    exp_t e;
    for (int k = 0; k < 3; k++) begin
      model_push(64'hC1 + 64'(k << 12), 1'b0);
      drive_refill(27'(k), 64'hC1 + 64'(k << 12), 1'b0);
      e = sb.pop_front();
      n_cmp++; if (o_wr !== e.wr || o_pte !== e.pte) begin n_err++;
        $display("FAIL gap_victim[%0d]: got wr=%h pte=%h want %h %h", k, o_wr, o_pte, e.wr, e.pte); end
    end
    n_cmp++; if (bus.entry_valid !== 32'h7) begin n_err++;
      $display("FAIL gap_valid: got %h want 00000007", bus.entry_valid); end
    bus.miss_valid = 1'b1;
    step();
    bus.miss_valid = 1'b0;
    n_cmp++; if (bus.ptw_req_valid !== 1'b1) begin n_err++;
      $display("FAIL req_state: got %b want 1", bus.ptw_req_valid); end
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    m_valid = '0;
    m_rr = 0;
    n_cmp++; if (bus.ptw_req_valid !== 1'b0 || bus.miss_ready !== 1'b1 || bus.entry_valid !== 32'h0)
    begin n_err++;
      $display("FAIL reset_in_req: got req=%b ready=%b valid=%h want 0/1/0",
               bus.ptw_req_valid, bus.miss_ready, bus.entry_valid); end
    // stale PTW response after reset is ignored
    bus.ptw_resp_pte   = 64'hCF;
    bus.ptw_resp_valid = 1'b1;
    step();
    bus.ptw_resp_valid = 1'b0;
    step();
    n_cmp++; if (bus.entry_valid !== 32'h0 || bus.miss_ready !== 1'b1 || bus.wr_en !== 32'h0)
    begin n_err++;
      $display("FAIL stale_resp: got valid=%h ready=%b wr=%h want 0/1/0",
               bus.entry_valid, bus.miss_ready, bus.wr_en); end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rstn  = 1'b0;
    bus.flush          = 1'b0;
    bus.miss_valid     = 1'b0;
    bus.miss_vpn       = '0;
    bus.ptw_req_ready  = 1'b0;
    bus.ptw_resp_valid = 1'b0;
    bus.ptw_resp_pte   = '0;
    bus.ptw_resp_fault = 1'b0;
    #1;
    test_reset();
    test_basic();
    test_fill_and_wrap();
    test_fault();
    test_flush_wait();
    test_flush_write();
    test_gap_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
